// File: rtl/midi_parser.sv
// midi_parser: byte-stream MIDI decoder feeding note events to the synth core.
// Tracks channel status (including running status), drops realtime/system bytes and
// unused channel messages, and emits one-cycle registered note strobes.
// Optional feature: define MIDI_PITCH_BEND_EN to add the bend_valid/bend_value outputs.
module midi_parser #(
    parameter int          BYTE_WIDTH   = 8,
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] data_in,
    input  logic                  data_in_ready,
    output logic                  note_valid,
    output logic                  note_on,
    output logic [6:0]            note_number,
    output logic [6:0]            velocity,
    output logic [3:0]            channel,
    output logic                  parse_error
`ifdef MIDI_PITCH_BEND_EN
    ,
    output logic                  bend_valid,
    output logic [13:0]           bend_value
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } state_t;

    state_t     state_r, state_nx_s;
    logic [3:0] type_r, type_nx_s;
    logic [3:0] chan_r, chan_nx_s;

    logic [7:0] byte_s;
    logic       is_rt_s, is_sys_s, is_status_s, is_data_s;
    logic       done_s, chan_en_s, note_evt_s, note_on_nx_s, perr_s;

    logic       note_valid_r, note_on_r, parse_error_r;
    logic [6:0] note_number_r, velocity_r;
    logic [3:0] channel_r;

`ifdef MIDI_PITCH_BEND_EN
    logic [6:0]  d1_r, d1_nx_s;
    logic        bend_evt_s;
    logic        bend_valid_r;
    logic [13:0] bend_value_r;
`endif

    assign byte_s      = data_in[7:0];
    assign is_rt_s     = (byte_s[7:3] == 5'b11111);
    assign is_sys_s    = (byte_s[7:4] == 4'hF) && !is_rt_s;
    assign is_status_s = byte_s[7] && (byte_s[7:4] != 4'hF);
    assign is_data_s   = !byte_s[7];

    // State register: parser state and running status (type, channel, first data byte).
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state_r <= ST_IDLE;
            type_r  <= 4'h0;
            chan_r  <= 4'h0;
`ifdef MIDI_PITCH_BEND_EN
            d1_r    <= 7'd0;
`endif
        end else begin
            state_r <= state_nx_s;
            type_r  <= type_nx_s;
            chan_r  <= chan_nx_s;
`ifdef MIDI_PITCH_BEND_EN
            d1_r    <= d1_nx_s;
`endif
        end
    end

    // Next-state logic: classify the incoming byte and advance the message parser.
    always_comb begin
        state_nx_s = state_r;
        type_nx_s  = type_r;
        chan_nx_s  = chan_r;
`ifdef MIDI_PITCH_BEND_EN
        d1_nx_s    = d1_r;
`endif
        if (!data_in_ready || is_rt_s) begin
            // realtime bytes are transparent: nothing moves
            state_nx_s = state_r;
        end else if (is_sys_s) begin
            state_nx_s = ST_IDLE;
            type_nx_s  = 4'h0;
            chan_nx_s  = 4'h0;
        end else if (is_status_s) begin
            state_nx_s = ST_WAIT_D1;
            type_nx_s  = byte_s[7:4];
            chan_nx_s  = byte_s[3:0];
        end else begin
            case (state_r)
                ST_IDLE:    state_nx_s = ST_IDLE;
                ST_WAIT_D1: begin
`ifdef MIDI_PITCH_BEND_EN
                    d1_nx_s = byte_s[6:0];
`endif
                    if ((type_r == 4'hC) || (type_r == 4'hD)) begin
                        state_nx_s = ST_WAIT_D1;
                    end else begin
                        state_nx_s = ST_WAIT_D2;
                    end
                end
                ST_WAIT_D2: state_nx_s = ST_WAIT_D1;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: detect completed messages, filter by channel mask, flag orphan data.
    always_comb begin
        done_s       = data_in_ready && is_data_s && (state_r == ST_WAIT_D2);
        chan_en_s    = CHANNEL_MASK[chan_r];
        note_evt_s   = done_s && chan_en_s && ((type_r == 4'h9) || (type_r == 4'h8));
        note_on_nx_s = (type_r == 4'h9) && (byte_s[6:0] != 7'd0);
        perr_s       = data_in_ready && is_data_s && (state_r == ST_IDLE);
`ifdef MIDI_PITCH_BEND_EN
        bend_evt_s   = done_s && chan_en_s && (type_r == 4'hE);
`endif
    end

    // Output registers: strobes last one cycle, payload changes only with a strobe.
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            note_valid_r  <= 1'b0;
            note_on_r     <= 1'b0;
            note_number_r <= 7'd0;
            velocity_r    <= 7'd0;
            channel_r     <= 4'd0;
            parse_error_r <= 1'b0;
`ifdef MIDI_PITCH_BEND_EN
            bend_valid_r  <= 1'b0;
            bend_value_r  <= 14'd0;
`endif
        end else begin
            note_valid_r  <= note_evt_s;
            parse_error_r <= perr_s;
            if (note_evt_s) begin
                note_on_r     <= note_on_nx_s;
                note_number_r <= d1_or_note();
                velocity_r    <= byte_s[6:0];
                channel_r     <= chan_r;
            end
`ifdef MIDI_PITCH_BEND_EN
            bend_valid_r <= bend_evt_s;
            if (bend_evt_s) begin
                bend_value_r <= {byte_s[6:0], d1_r};
                channel_r    <= chan_r;
            end
`endif
        end
    end

    // The note number is the first data byte of the message.
`ifdef MIDI_PITCH_BEND_EN
    function automatic logic [6:0] d1_or_note();
        return d1_r;
    endfunction
`else
    logic [6:0] note_d1_r;

    // First data byte holder for note messages when bend support is not built.
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            note_d1_r <= 7'd0;
        end else if (data_in_ready && is_data_s && (state_r == ST_WAIT_D1)) begin
            note_d1_r <= byte_s[6:0];
        end else begin
            note_d1_r <= note_d1_r;
        end
    end

    function automatic logic [6:0] d1_or_note();
        return note_d1_r;
    endfunction
`endif

    assign note_valid  = note_valid_r;
    assign note_on     = note_on_r;
    assign note_number = note_number_r;
    assign velocity    = velocity_r;
    assign channel     = channel_r;
    assign parse_error = parse_error_r;
`ifdef MIDI_PITCH_BEND_EN
    assign bend_valid  = bend_valid_r;
    assign bend_value  = bend_value_r;
`endif

endmodule
